// File: rtl/udp_rx_port_filter.sv
// UDP receive stage: parses the 8-byte UDP header from an IP payload stream,
// filters on protocol/port/length and forwards a length-trimmed payload.
module udp_rx_port_filter #(
  parameter int ENABLE_PORT_FILTER = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_ip_hdr_valid,
  output logic        s_ip_hdr_ready,
  input  logic [7:0]  s_ip_protocol,
  input  logic [15:0] s_ip_length,
  input  logic [31:0] s_ip_source_ip,
  input  logic [31:0] s_ip_dest_ip,
  input  logic [7:0]  s_ip_payload_axis_tdata,
  input  logic        s_ip_payload_axis_tvalid,
  output logic        s_ip_payload_axis_tready,
  input  logic        s_ip_payload_axis_tlast,
  input  logic        s_ip_payload_axis_tuser,
  input  logic [15:0] listen_port,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [31:0] m_udp_source_ip,
  output logic [31:0] m_udp_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser,
  output logic        drop_pulse,
  output logic [15:0] drop_count
);

  localparam logic [7:0] PROTO_UDP = 8'd17;

  typedef enum logic [2:0] {IDLE, HDR, OUTHDR, PAYLOAD, DROP} state_t;

  state_t      r_state;
  logic        r_hdr_ready;
  logic        r_hdr_valid;
  logic [2:0]  r_byte_cnt;
  logic [15:0] r_ip_length;
  logic [31:0] r_src_ip;
  logic [31:0] r_dst_ip;
  logic [15:0] r_src_port;
  logic [15:0] r_dst_port;
  logic [15:0] r_udp_len;
  logic [15:0] r_remaining;
  logic        r_drop_pulse;
  logic [15:0] r_drop_count;

  logic w_in_payload;
  logic w_s_tready;
  logic w_beat;
  logic w_rem_last;
  logic w_len_ok;
  logic w_port_ok;

  assign w_in_payload = (r_state == PAYLOAD);
  assign w_s_tready   = (r_state == HDR) || (r_state == DROP) ||
                        (w_in_payload && m_udp_payload_axis_tready);
  assign w_beat       = s_ip_payload_axis_tvalid && w_s_tready;
  assign w_rem_last   = (r_remaining == 16'd1);
  // 17-bit compare so a short IP length cannot underflow into a huge limit
  assign w_len_ok     = (r_udp_len >= 16'd9) &&
                        (({1'b0, r_udp_len} + 17'd20) <= {1'b0, r_ip_length});
  assign w_port_ok    = (ENABLE_PORT_FILTER == 0) || (r_dst_port == listen_port);

  assign s_ip_hdr_ready           = r_hdr_ready;
  assign s_ip_payload_axis_tready = w_s_tready;
  assign m_udp_hdr_valid          = r_hdr_valid;
  assign m_udp_source_ip          = r_src_ip;
  assign m_udp_dest_ip            = r_dst_ip;
  assign m_udp_source_port        = r_src_port;
  assign m_udp_dest_port          = r_dst_port;
  assign m_udp_length             = r_udp_len;
  assign drop_pulse               = r_drop_pulse;
  assign drop_count               = r_drop_count;

  assign m_udp_payload_axis_tdata  = w_in_payload ? s_ip_payload_axis_tdata : 8'd0;
  assign m_udp_payload_axis_tvalid = w_in_payload && s_ip_payload_axis_tvalid;
  assign m_udp_payload_axis_tlast  = w_in_payload && (s_ip_payload_axis_tlast || w_rem_last);
  // Early tlast means the datagram was truncated upstream: flag it as errored
  assign m_udp_payload_axis_tuser  = w_in_payload &&
                                     (s_ip_payload_axis_tuser ||
                                      (s_ip_payload_axis_tlast && !w_rem_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hdr_ready  <= 1'b0;
      r_hdr_valid  <= 1'b0;
      r_byte_cnt   <= 3'd0;
      r_ip_length  <= 16'd0;
      r_src_ip     <= 32'd0;
      r_dst_ip     <= 32'd0;
      r_src_port   <= 16'd0;
      r_dst_port   <= 16'd0;
      r_udp_len    <= 16'd0;
      r_remaining  <= 16'd0;
      r_drop_pulse <= 1'b0;
      r_drop_count <= 16'd0;
    end else begin
      r_drop_pulse <= 1'b0;
      if (r_drop_pulse && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
      case (r_state)
        IDLE: begin
          if (!r_hdr_ready) begin
            r_hdr_ready <= 1'b1;
          end else if (s_ip_hdr_valid) begin
            r_hdr_ready <= 1'b0;
            r_src_ip    <= s_ip_source_ip;
            r_dst_ip    <= s_ip_dest_ip;
            r_ip_length <= s_ip_length;
            r_byte_cnt  <= 3'd0;
            if (s_ip_protocol == PROTO_UDP) begin
              r_state <= HDR;
            end else begin
              r_state      <= DROP;
              r_drop_pulse <= 1'b1;
            end
          end
        end
        HDR: begin
          if (w_beat) begin
            r_byte_cnt <= r_byte_cnt + 3'd1;
            case (r_byte_cnt)
              3'd0: r_src_port[15:8] <= s_ip_payload_axis_tdata;
              3'd1: r_src_port[7:0]  <= s_ip_payload_axis_tdata;
              3'd2: r_dst_port[15:8] <= s_ip_payload_axis_tdata;
              3'd3: r_dst_port[7:0]  <= s_ip_payload_axis_tdata;
              3'd4: r_udp_len[15:8]  <= s_ip_payload_axis_tdata;
              3'd5: r_udp_len[7:0]   <= s_ip_payload_axis_tdata;
              default: ;
            endcase
            if (r_byte_cnt == 3'd7) begin
              if (w_len_ok && w_port_ok && !s_ip_payload_axis_tlast) begin
                r_state     <= OUTHDR;
                r_hdr_valid <= 1'b1;
              end else begin
                r_drop_pulse <= 1'b1;
                if (s_ip_payload_axis_tlast) begin
                  r_state     <= IDLE;
                  r_hdr_ready <= 1'b1;
                end else begin
                  r_state <= DROP;
                end
              end
            end else if (s_ip_payload_axis_tlast) begin
              r_drop_pulse <= 1'b1;
              r_state      <= IDLE;
              r_hdr_ready  <= 1'b1;
            end
          end
        end
        OUTHDR: begin
          if (m_udp_hdr_ready) begin
            r_hdr_valid <= 1'b0;
            r_remaining <= r_udp_len - 16'd8;
            r_state     <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (w_beat) begin
            if (w_rem_last) begin
              // Bytes beyond the UDP length are Ethernet padding: swallow them
              if (s_ip_payload_axis_tlast) begin
                r_state     <= IDLE;
                r_hdr_ready <= 1'b1;
              end else begin
                r_state <= DROP;
              end
            end else if (s_ip_payload_axis_tlast) begin
              r_drop_pulse <= 1'b1;
              r_state      <= IDLE;
              r_hdr_ready  <= 1'b1;
            end else begin
              r_remaining <= r_remaining - 16'd1;
            end
          end
        end
        DROP: begin
          if (w_beat && s_ip_payload_axis_tlast) begin
            r_state     <= IDLE;
            r_hdr_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_hdr_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_port_filter.sv
// Scoreboard bench for udp_rx_port_filter: two instances (port filter on/off)
// share one stimulus driver selected by sel.
module tb_udp_rx_port_filter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel;
  logic        d_hdr_valid;
  logic [7:0]  d_proto;
  logic [15:0] d_ip_len;
  logic [31:0] d_sip, d_dip;
  logic [7:0]  d_tdata;
  logic        d_tvalid, d_tlast, d_tuser;
  logic [15:0] listen_port;
  logic        m_hdr_ready, m_tready;

  logic        o_hr [2];
  logic        o_str[2];
  logic        o_hv [2];
  logic [31:0] o_sip[2];
  logic [31:0] o_dip[2];
  logic [15:0] o_sp [2];
  logic [15:0] o_dp [2];
  logic [15:0] o_len[2];
  logic [7:0]  o_td [2];
  logic        o_tv [2];
  logic        o_tl [2];
  logic        o_tu [2];
  logic        o_dpl[2];
  logic [15:0] o_dc [2];

  udp_rx_port_filter #(.ENABLE_PORT_FILTER(1)) dut0 (
    .clk(clk), .rst(rst),
    .s_ip_hdr_valid(d_hdr_valid && !sel), .s_ip_hdr_ready(o_hr[0]),
    .s_ip_protocol(d_proto), .s_ip_length(d_ip_len),
    .s_ip_source_ip(d_sip), .s_ip_dest_ip(d_dip),
    .s_ip_payload_axis_tdata(d_tdata), .s_ip_payload_axis_tvalid(d_tvalid && !sel),
    .s_ip_payload_axis_tready(o_str[0]), .s_ip_payload_axis_tlast(d_tlast),
    .s_ip_payload_axis_tuser(d_tuser), .listen_port(listen_port),
    .m_udp_hdr_valid(o_hv[0]), .m_udp_hdr_ready(m_hdr_ready),
    .m_udp_source_ip(o_sip[0]), .m_udp_dest_ip(o_dip[0]),
    .m_udp_source_port(o_sp[0]), .m_udp_dest_port(o_dp[0]), .m_udp_length(o_len[0]),
    .m_udp_payload_axis_tdata(o_td[0]), .m_udp_payload_axis_tvalid(o_tv[0]),
    .m_udp_payload_axis_tready(m_tready), .m_udp_payload_axis_tlast(o_tl[0]),
    .m_udp_payload_axis_tuser(o_tu[0]), .drop_pulse(o_dpl[0]), .drop_count(o_dc[0])
  );

  udp_rx_port_filter #(.ENABLE_PORT_FILTER(0)) dut1 (
    .clk(clk), .rst(rst),
    .s_ip_hdr_valid(d_hdr_valid && sel), .s_ip_hdr_ready(o_hr[1]),
    .s_ip_protocol(d_proto), .s_ip_length(d_ip_len),
    .s_ip_source_ip(d_sip), .s_ip_dest_ip(d_dip),
    .s_ip_payload_axis_tdata(d_tdata), .s_ip_payload_axis_tvalid(d_tvalid && sel),
    .s_ip_payload_axis_tready(o_str[1]), .s_ip_payload_axis_tlast(d_tlast),
    .s_ip_payload_axis_tuser(d_tuser), .listen_port(listen_port),
    .m_udp_hdr_valid(o_hv[1]), .m_udp_hdr_ready(m_hdr_ready),
    .m_udp_source_ip(o_sip[1]), .m_udp_dest_ip(o_dip[1]),
    .m_udp_source_port(o_sp[1]), .m_udp_dest_port(o_dp[1]), .m_udp_length(o_len[1]),
    .m_udp_payload_axis_tdata(o_td[1]), .m_udp_payload_axis_tvalid(o_tv[1]),
    .m_udp_payload_axis_tready(m_tready), .m_udp_payload_axis_tlast(o_tl[1]),
    .m_udp_payload_axis_tuser(o_tu[1]), .drop_pulse(o_dpl[1]), .drop_count(o_dc[1])
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t        exp_beats[$];
  logic [111:0] exp_hdr[$];
  int n_checks = 0;
  int n_err    = 0;
  int drop_seen0 = 0;
  int exp_drops0 = 0;
  logic rnd_en = 1'b0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] pay(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin : mon
    beat_t b;
    if (!rst) begin
      if (o_hv[sel]) begin
        if (exp_hdr.size() == 0) chk("hdr_unexpected", 128'(1), 128'(0));
        else begin
          chk("hdr_fields", 128'({o_sip[sel], o_dip[sel], o_sp[sel], o_dp[sel], o_len[sel]}),
              128'(exp_hdr[0]));
          if (m_hdr_ready) void'(exp_hdr.pop_front());
        end
      end
      if (o_tv[sel]) begin
        chk("tready_mirror", 128'(o_str[sel]), 128'(m_tready));
        if (m_tready) begin
          if (exp_beats.size() == 0) chk("beat_unexpected", 128'(1), 128'(0));
          else begin
            b = exp_beats.pop_front();
            chk("beat", 128'({o_td[sel], o_tl[sel], o_tu[sel]}), 128'(b));
          end
        end
      end
      if (o_dpl[0]) drop_seen0++;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_en) m_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send_hdr(input logic [7:0] proto, input logic [15:0] iplen);
    bit ok = 0;
    int n = 0;
    d_proto = proto; d_ip_len = iplen; d_hdr_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk); ok = o_hr[sel];
      tick; n++;
    end
    d_hdr_valid = 1'b0;
    if (!ok) chk("hdr_hs_timeout", 128'(0), 128'(1));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit ok = 0;
    int n = 0;
    d_tdata = b; d_tlast = last; d_tuser = 1'b0; d_tvalid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk); ok = o_str[sel];
      tick; n++;
    end
    d_tvalid = 1'b0; d_tlast = 1'b0;
    if (!ok) chk("beat_hs_timeout", 128'(0), 128'(1));
  endtask

  task automatic send_frame(input logic [7:0] proto, input logic [15:0] iplen,
                            input logic [15:0] sp, input logic [15:0] dp,
                            input logic [15:0] ulen, input int n);
    logic [7:0] b;
    send_hdr(proto, iplen);
    for (int i = 0; i < n; i++) begin
      case (i)
        0: b = sp[15:8];
        1: b = sp[7:0];
        2: b = dp[15:8];
        3: b = dp[7:0];
        4: b = ulen[15:8];
        5: b = ulen[7:0];
        6, 7: b = 8'h00;
        default: b = pay(i - 8);
      endcase
      send_byte(b, i == n - 1);
    end
  endtask

  task automatic push_hdr(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] ulen);
    exp_hdr.push_back({d_sip, d_dip, sp, dp, ulen});
  endtask

  task automatic push_beats(input int n, input logic trunc);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = pay(i);
      b.l = (i == n - 1);
      b.u = trunc && (i == n - 1);
      exp_beats.push_back(b);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_beats.size() != 0 || exp_hdr.size() != 0) && n < 500) begin
      tick; n++;
    end
    chk({tag, "_drain"}, 128'(exp_beats.size() + exp_hdr.size()), 128'(0));
    repeat (4) tick;
    chk({tag, "_drop_pulses"}, 128'(drop_seen0), 128'(exp_drops0));
    chk({tag, "_drop_count"}, 128'(o_dc[0]), 128'(exp_drops0));
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0;
    d_hdr_valid = 0; d_proto = 0; d_ip_len = 0; d_tdata = 0;
    d_tvalid = 0; d_tlast = 0; d_tuser = 0;
    d_sip = 32'hC0A8_0001; d_dip = 32'hC0A8_0002;
    listen_port = 16'd7400; m_hdr_ready = 1'b1; m_tready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hdr_ready", 128'(o_hr[0]), 128'(0));
    chk("rst_hdr_valid", 128'(o_hv[0]), 128'(0));
    chk("rst_tready", 128'(o_str[0]), 128'(0));
    chk("rst_tvalid", 128'(o_tv[0]), 128'(0));
    chk("rst_drop_count", 128'(o_dc[0]), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("hdr_ready_pre", 128'(o_hr[0]), 128'(0));
    @(negedge clk);
    chk("hdr_ready_up", 128'(o_hr[0]), 128'(1));
    tick;

    // Basic accepted datagram
    push_hdr(16'h1234, 16'd7400, 16'h0010);
    push_beats(8, 1'b0);
    send_frame(8'd17, 16'h0024, 16'h1234, 16'd7400, 16'h0010, 16);
    wait_done("basic");

    // Ethernet padding after the datagram
    push_hdr(16'h1234, 16'd7400, 16'h0010);
    push_beats(8, 1'b0);
    send_frame(8'd17, 16'h0024, 16'h1234, 16'd7400, 16'h0010, 22);
    wait_done("padding");

    // Port mismatch with filter enabled
    send_frame(8'd17, 16'h0024, 16'h1234, 16'd7401, 16'h0010, 16);
    exp_drops0 = 1;
    wait_done("port_drop");

    // Same frame, filter disabled instance
    sel = 1'b1; tick;
    push_hdr(16'h1234, 16'd7401, 16'h0010);
    push_beats(8, 1'b0);
    send_frame(8'd17, 16'h0024, 16'h1234, 16'd7401, 16'h0010, 16);
    wait_done("nofilter");
    chk("nofilter_drop_count", 128'(o_dc[1]), 128'(0));
    sel = 1'b0; tick;

    // TCP then UDP back-to-back
    push_hdr(16'hABCD, 16'd7400, 16'h0010);
    push_beats(8, 1'b0);
    send_frame(8'd6, 16'h0024, 16'h1234, 16'd7400, 16'h0010, 16);
    send_frame(8'd17, 16'h0024, 16'hABCD, 16'd7400, 16'h0010, 16);
    exp_drops0 = 2;
    wait_done("tcp_then_udp");

    // Truncated datagram
    push_hdr(16'h0101, 16'd7400, 16'h0020);
    push_beats(10, 1'b1);
    send_frame(8'd17, 16'h0034, 16'h0101, 16'd7400, 16'h0020, 18);
    exp_drops0 = 3;
    wait_done("truncated");

    // Zero-payload datagram, tlast on the last header byte
    send_frame(8'd17, 16'h001C, 16'h0202, 16'd7400, 16'h0008, 8);
    exp_drops0 = 4;
    wait_done("zero_payload");

    // Header cut short
    send_frame(8'd17, 16'h0024, 16'h0303, 16'd7400, 16'h0010, 4);
    exp_drops0 = 5;
    wait_done("short_hdr");

    // UDP length larger than the IP payload
    send_frame(8'd17, 16'h0020, 16'h0404, 16'd7400, 16'h0010, 16);
    exp_drops0 = 6;
    wait_done("len_too_big");

    // Header backpressure and random payload backpressure
    m_hdr_ready = 1'b0;
    rnd_en = 1'b1;
    push_hdr(16'h5555, 16'd7400, 16'h0010);
    push_beats(8, 1'b0);
    fork
      begin repeat (20) tick; m_hdr_ready = 1'b1; end
      send_frame(8'd17, 16'h0024, 16'h5555, 16'd7400, 16'h0010, 16);
    join
    rnd_en = 1'b0;
    tick;
    m_tready = 1'b1;
    wait_done("backpressure");

    // A valid frame still passes after all the drops
    push_hdr(16'h0606, 16'd7400, 16'h0011);
    push_beats(9, 1'b0);
    send_frame(8'd17, 16'h0025, 16'h0606, 16'd7400, 16'h0011, 17);
    wait_done("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
